// File: rtl/booth_pkg.sv
// Shared types, widths and the operand-conditioning rule for the Booth multiplier controller.
// Purely declarative: no latency, no flow control.
package booth_pkg;

    localparam int BOOTH_OPW  = 4;
    localparam int BOOTH_PW   = 8;
    localparam int BOOTH_ITER = 4;
    localparam int BOOTH_CNTW = 3;

    localparam logic [BOOTH_OPW-1:0] BOOTH_MOST_NEG    = 4'b1000;
    localparam logic [BOOTH_PW-1:0]  BOOTH_BYPASS_PROD = 8'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } booth_ctrl_state_t;

    typedef struct packed {
        logic [BOOTH_OPW-1:0] a;
        logic [BOOTH_OPW-1:0] b;
        logic                 bypass;
    } booth_ops_t;

    // The core's 4-bit partial sum cannot hold -(-8); move -8 to the multiplier
    // side, and when both operands are -8 the result is substituted instead.
    function automatic booth_ops_t booth_condition(
        input logic [BOOTH_OPW-1:0] a,
        input logic [BOOTH_OPW-1:0] b
    );
        booth_ops_t ops;
        ops.a      = a;
        ops.b      = b;
        ops.bypass = 1'b0;
        if (a == BOOTH_MOST_NEG) begin
            if (b == BOOTH_MOST_NEG) begin
                ops.bypass = 1'b1;
            end else begin
                ops.a = b;
                ops.b = BOOTH_MOST_NEG;
            end
        end
        return ops;
    endfunction

endpackage

// File: rtl/booth_acc.sv
// Running signed sum of captured products, wrapping modulo 2^ACC_W.
// Latency: updates on the capture edge. Backpressure: none, follows the capture strobe.
// Clear wins over the old sum; clear with capture leaves just the new product.
module booth_acc
    import booth_pkg::*;
#(
    parameter int ACC_W = 12
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cap,
    input  logic                clr,
    input  logic [BOOTH_PW-1:0] prod,
    output logic [ACC_W-1:0]    acc
);

    logic [ACC_W-1:0] prod_ext;

    assign prod_ext = {{(ACC_W-BOOTH_PW){prod[BOOTH_PW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= cap ? prod_ext : '0;
        end else if (cap) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Operand-issue / result-capture controller for the 4-bit radix-2 Booth core; BOOTH_MAC_ACC_EN adds an accumulator.
// Latency: 6 cycles from input accept to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so inputs stall meanwhile.
module booth_mul_ctrl
    import booth_pkg::*;
`ifdef BOOTH_MAC_ACC_EN
#(
    parameter int ACC_W = 12
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BOOTH_OPW-1:0] in_a,
    input  logic [BOOTH_OPW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BOOTH_PW-1:0]  out_prod,
    output logic                 mul_start,
    output logic [BOOTH_OPW-1:0] mul_a,
    output logic [BOOTH_OPW-1:0] mul_b,
    input  logic [2:0]           mul_n,
    input  logic [BOOTH_PW-1:0]  mul_axb,
    output logic                 seq_err
`ifdef BOOTH_MAC_ACC_EN
    ,
    input  logic                 acc_clr,
    output logic [ACC_W-1:0]     acc_out
`endif
);

    booth_ctrl_state_t     state;
    logic [BOOTH_CNTW-1:0] cnt;
    logic                  bypass;
    booth_ops_t            ops;
    logic                  cap;
    logic [BOOTH_PW-1:0]   cap_prod;

    assign ops      = booth_condition(in_a, in_b);
    assign cap      = (state == RUN) && (cnt == '0);
    assign cap_prod = bypass ? BOOTH_BYPASS_PROD : mul_axb;
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_prod  <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            cnt       <= '0;
            bypass    <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a     <= ops.a;
                        mul_b     <= ops.b;
                        bypass    <= ops.bypass;
                        mul_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= BOOTH_CNTW'(BOOTH_ITER);
                    state <= RUN;
                end
                RUN: begin
                    // cnt tracks the core's own countdown; a mismatch at capture means the core drifted
                    if (cap) begin
                        out_prod  <= cap_prod;
                        out_valid <= 1'b1;
                        if (mul_n != 3'd0) begin
                            seq_err <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOTH_MAC_ACC_EN
    booth_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .cap  (cap),
        .clr  (acc_clr),
        .prod (cap_prod),
        .acc  (acc_out)
    );
`endif

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Randomized self-checking bench for booth_mul_ctrl with a behavioural Booth core and product model.
module tb_booth_mul_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_prod;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [2:0] core_n = '0;
    logic [7:0] core_p = '0;
    logic       seq_err;
    bit         core_slow = 1'b0;
`ifdef BOOTH_MAC_ACC_EN
    logic        acc_clr = 1'b0;
    logic [11:0] acc_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int start_seen = 0;

    booth_mul_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_n     (core_n),
        .mul_axb   (core_p),
        .seq_err   (seq_err)
`ifdef BOOTH_MAC_ACC_EN
        ,
        .acc_clr   (acc_clr),
        .acc_out   (acc_out)
`endif
    );

    initial forever #5 clk = ~clk;

    // Core behaviour: the plain signed product, except -8 x -8, which wraps.
    function automatic logic [7:0] core_result(input logic [3:0] a, input logic [3:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (a == 4'b1000 && b == 4'b1000) return 8'hC0;
        return 8'(sa * sb);
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            core_n <= core_slow ? 3'd5 : 3'd4;
            core_p <= 8'hA5;
        end else if (core_n != 3'd0) begin
            core_n <= core_n - 3'd1;
            if (core_n == 3'd1) core_p <= core_result(mul_a, mul_b);
        end
    end

    always @(negedge clk) if (mul_start) start_seen++;

    // Reference: true product, and where the operands should sit on the core.
    function automatic logic [7:0] ref_prod(input int a, input int b);
        return 8'(a * b);
    endfunction

    function automatic logic [7:0] ref_ops(input int a, input int b);
        logic [3:0] ra, rb;
        ra = 4'(a);
        rb = 4'(b);
        if (a == -8 && b != -8) return {rb, 4'b1000};
        return {ra, rb};
    endfunction

    // Returns at E0 + 1ns; waited = -1 if never accepted.
    task automatic send(input int a, input int b, output int waited);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 4'(a);
        in_b = 4'(b);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            waited = -1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 4'($urandom);
        in_b = 4'($urandom);
    endtask

    // Cycles after accept until out_valid is seen (-1 on timeout); ends at a negedge.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_prod !== 8'h00) begin n_bad++; $display("FAIL reset_out_prod: got %h want 00", out_prod); end
        n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        n_cmp++; if ({mul_a, mul_b} !== 8'h00) begin n_bad++; $display("FAIL reset_mul_ops: got %h want 00", {mul_a, mul_b}); end
        n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
`ifdef BOOTH_MAC_ACC_EN
        n_cmp++; if (acc_out !== 12'h000) begin n_bad++; $display("FAIL reset_acc: got %h want 000", acc_out); end
`endif
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int w, lat, s0;
        s0 = start_seen;
        send(3, 5, w);
        wait_out(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_cmp++; if (out_prod !== 8'h0F) begin n_bad++; $display("FAIL basic_prod: got %h want 0f", out_prod); end
        n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL basic_seq_err: got %b want 0", seq_err); end
        n_cmp++; if ({mul_a, mul_b} !== 8'h35) begin n_bad++; $display("FAIL basic_mul_ops: got %h want 35", {mul_a, mul_b}); end
        n_cmp++; if (start_seen - s0 !== 1) begin n_bad++; $display("FAIL basic_start_pulses: got %0d want 1", start_seen - s0); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_in_done: got %b want 0", in_ready); end
        retire();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_retire: got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_swap();
        int w, lat;
        send(-8, 3, w);
        wait_out(lat);
        n_cmp++; if ({mul_a, mul_b} !== 8'h38) begin n_bad++; $display("FAIL swap_mul_ops: got %h want 38", {mul_a, mul_b}); end
        n_cmp++; if (out_prod !== 8'hE8) begin n_bad++; $display("FAIL swap_prod: got %h want e8", out_prod); end
        retire();
    endtask

    task automatic test_bypass();
        int w, lat;
        send(-8, -8, w);
        wait_out(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL bypass_latency: got %0d want 6", lat); end
        n_cmp++; if (out_prod !== 8'h40) begin n_bad++; $display("FAIL bypass_prod: got %h want 40", out_prod); end
        n_cmp++; if ({mul_a, mul_b} !== 8'h88) begin n_bad++; $display("FAIL bypass_mul_ops: got %h want 88", {mul_a, mul_b}); end
        retire();
    endtask

    task automatic test_random();
        int a, b, w, lat;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 15)) - 8;
            b = int'($urandom_range(0, 15)) - 8;
            if (i == 0) begin a = -8; b = -8; end
            send(a, b, w);
            wait_out(lat);
            n_cmp++; if (lat !== 6 || out_prod !== ref_prod(a, b)) begin
                n_bad++; $display("FAIL random_prod %0d*%0d: got %h lat %0d want %h lat 6", a, b, out_prod, lat, ref_prod(a, b));
            end
            n_cmp++; if ({mul_a, mul_b} !== ref_ops(a, b)) begin
                n_bad++; $display("FAIL random_mul_ops %0d*%0d: got %h want %h", a, b, {mul_a, mul_b}, ref_ops(a, b));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            retire();
        end
    endtask

    task automatic test_back_pressure();
        int w, lat, bad;
        send(2, -3, w);
        wait_out(lat);
        in_valid = 1'b1;
        in_a = 4'd1;
        in_b = 4'd1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_prod !== 8'hFA || in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        n_cmp++; if (mul_a !== 4'd2) begin n_bad++; $display("FAIL bp_mul_a_stable: got %h want 2", mul_a); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_after_take: got ready %b valid %b want 1 0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0 || mul_start !== 1'b1 || mul_a !== 4'd1) begin
            n_bad++; $display("FAIL bp_next_accept: got ready %b start %b mul_a %h want 0 1 1", in_ready, mul_start, mul_a);
        end
        wait_out(lat);
        n_cmp++; if (lat !== 6 || out_prod !== 8'h01) begin n_bad++; $display("FAIL bp_next_prod: got %h lat %0d want 01 lat 6", out_prod, lat); end
        retire();
    endtask

    task automatic test_reset_midrun();
        int w, lat, stale;
        send(5, 5, w);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got valid %b ready %b want 0 0", out_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d valid cycles want 0", stale); end
        send(2, 2, w);
        wait_out(lat);
        n_cmp++; if (lat !== 6 || out_prod !== 8'h04) begin n_bad++; $display("FAIL midrst_after: got %h lat %0d want 04 lat 6", out_prod, lat); end
        retire();
    endtask

`ifdef BOOTH_MAC_ACC_EN
    task automatic test_accumulate();
        int w, lat, a, b, model;
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        n_cmp++; if (acc_out !== 12'h000) begin n_bad++; $display("FAIL acc_clear: got %h want 000", acc_out); end
        send(7, 7, w);
        wait_out(lat);
        n_cmp++; if (acc_out !== 12'd49) begin n_bad++; $display("FAIL acc_49: got %0d want 49", acc_out); end
        retire();
        send(-7, 7, w);
        wait_out(lat);
        n_cmp++; if (acc_out !== 12'd0) begin n_bad++; $display("FAIL acc_back_to_0: got %0d want 0", acc_out); end
        retire();
        acc_clr = 1'b0;
        send(2, 3, w);
        repeat (5) @(posedge clk);
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || acc_out !== 12'd6) begin n_bad++; $display("FAIL acc_clr_with_cap: got valid %b acc %0d want 1 6", out_valid, acc_out); end
        retire();
        model = 6;
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 15)) - 8;
            b = int'($urandom_range(0, 15)) - 8;
            send(a, b, w);
            wait_out(lat);
            model += a * b;
            n_cmp++; if (acc_out !== 12'(model)) begin n_bad++; $display("FAIL acc_random %0d*%0d: got %h want %h", a, b, acc_out, 12'(model)); end
            retire();
        end
    endtask
`endif

    task automatic test_seq_err();
        int w, lat;
        core_slow = 1'b1;
        send(1, 1, w);
        wait_out(lat);
        n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL seq_err_set: got %b want 1", seq_err); end
        retire();
        core_slow = 1'b0;
        send(1, 2, w);
        wait_out(lat);
        n_cmp++; if (seq_err !== 1'b1 || out_prod !== 8'h02) begin n_bad++; $display("FAIL seq_err_sticky: got err %b prod %h want 1 02", seq_err, out_prod); end
        retire();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_bypass();
        test_random();
        test_back_pressure();
        test_reset_midrun();
`ifdef BOOTH_MAC_ACC_EN
        test_accumulate();
`endif
        test_seq_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
